// File: rtl/pll_lock_phase_gen.sv
// pll_lock_phase_gen
//   Qualifies a raw PLL lock with a two-flop synchroniser and a hold-off
//   counter, then generates NUM_CH divided clocks from clock_in. Each channel
//   has its own phase offset in whole clock_in cycles. Divide and phase are
//   reconfigured through a one-deep shadow register. In RUN the new values
//   only take effect at a period boundary, so the old period always completes
//   and no runt pulses are produced.
//
// Ports
//   clock_in      : PLL output clock; the only clock
//   resetb        : asynchronous active-low reset
//   pll_locked    : raw PLL lock, asynchronous to clock_in
//   cfg_valid     : new configuration offered
//   cfg_ready     : shadow slot free (transfer on cfg_valid & cfg_ready)
//   cfg_div       : divide value; period = cfg_div + 1 cycles
//   cfg_phase     : per-channel phase; channel i at [i*DIV_W +: DIV_W]
//   clk_out       : divided, phase-shifted clocks (registered)
//   tick          : one-cycle strobe coinciding with each clk_out rising edge
//   running       : high while in RUN
//   unlock_count  : saturating count of RUN -> IDLE lock losses
module pll_lock_phase_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3,
    parameter int LOCK_WAIT   = 1024
) (
    input  logic                    clock_in,
    input  logic                    resetb,
    input  logic                    pll_locked,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic                    running,
    output logic [7:0]              unlock_count
);

    localparam int WCNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t                               state_q, state_d;
    logic [1:0]                           sync_q;
    logic [WCNT_W-1:0]                    wait_cnt_q, wait_cnt_d;
    logic [DIV_W-1:0]                     cnt_q, cnt_d;
    logic [DIV_W-1:0]                     div_act_q, div_act_d;
    logic [NUM_CH-1:0][DIV_W-1:0]         phase_act_q, phase_act_d;
    logic [DIV_W-1:0]                     shd_div_q, shd_div_d;
    logic [NUM_CH*DIV_W-1:0]              shd_phase_q, shd_phase_d;
    logic                                 pend_q, pend_d;
    logic [NUM_CH-1:0]                    clk_out_q, clk_out_d;
    logic [NUM_CH-1:0]                    tick_q, tick_d;
    logic [7:0]                           unlock_q, unlock_d;

    logic                                 lock_s;
    logic [DIV_W-1:0]                     div_eff;
    logic [DIV_W:0]                       period;
    logic [DIV_W:0]                       hi;
    logic                                 period_end;
    logic                                 apply;
    logic [NUM_CH-1:0]                    pos_lo;
    logic [NUM_CH-1:0]                    pos_zero;

    assign lock_s     = sync_q[1];
    // A divide of 0 would give a one-cycle period with no low phase.
    assign div_eff    = (div_act_q == '0) ? DIV_W'(1) : div_act_q;
    assign period     = {1'b0, div_eff} + (DIV_W+1)'(1);
    assign hi         = period >> 1;
    assign period_end = (cnt_q == div_eff);

    // Position of each channel within its own period, phase clamped to div.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] ph;
        logic [DIV_W:0]   pos;
        assign ph  = (phase_act_q[gi] > div_act_q) ? div_act_q : phase_act_q[gi];
        assign pos = (cnt_q >= ph) ? ({1'b0, cnt_q} - {1'b0, ph})
                                   : ({1'b0, cnt_q} + period - {1'b0, ph});
        assign pos_lo[gi]   = (pos < hi);
        assign pos_zero[gi] = (pos == '0);
    end

    // Shadow goes live at a period boundary in RUN, immediately otherwise.
    assign apply = pend_q && ((state_q != ST_RUN) || period_end);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cnt_d       = cnt_q;
        div_act_d   = div_act_q;
        phase_act_d = phase_act_q;
        shd_div_d   = shd_div_q;
        shd_phase_d = shd_phase_q;
        pend_d      = pend_q;
        clk_out_d   = '0;
        tick_d      = '0;
        unlock_d    = unlock_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    // Outputs are already forced low on the same edge that
                    // leaves RUN, so a lost lock never yields a stray pulse.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (unlock_q != 8'hFF) begin
                        unlock_d = unlock_q + 8'd1;
                    end
                end else begin
                    cnt_d     = period_end ? '0 : (cnt_q + DIV_W'(1));
                    clk_out_d = pos_lo;
                    tick_d    = pos_zero;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Transfer and apply are mutually exclusive: a transfer needs an
        // empty slot, an apply needs a full one.
        if (apply) begin
            div_act_d   = shd_div_q;
            phase_act_d = shd_phase_q;
            pend_d      = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            shd_div_d   = cfg_div;
            shd_phase_d = cfg_phase;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            wait_cnt_q  <= '0;
            cnt_q       <= '0;
            div_act_q   <= DIV_RST;
            phase_act_q <= '0;
            shd_div_q   <= '0;
            shd_phase_q <= '0;
            pend_q      <= 1'b0;
            clk_out_q   <= '0;
            tick_q      <= '0;
            unlock_q    <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], pll_locked};
            wait_cnt_q  <= wait_cnt_d;
            cnt_q       <= cnt_d;
            div_act_q   <= div_act_d;
            phase_act_q <= phase_act_d;
            shd_div_q   <= shd_div_d;
            shd_phase_q <= shd_phase_d;
            pend_q      <= pend_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            unlock_q    <= unlock_d;
        end
    end

    assign cfg_ready    = ~pend_q;
    assign clk_out      = clk_out_q;
    assign tick         = tick_q;
    assign running      = (state_q == ST_RUN);
    assign unlock_count = unlock_q;

endmodule

// File: tb/tb_pll_lock_phase_gen.sv
// tb_pll_lock_phase_gen
//   Scoreboard bench. A reference model computes the expected outputs at each
//   rising edge from lock history, the active divide/phase and the period
//   position, and queues them. A monitor pops one entry per falling edge and
//   compares it with the DUT outputs. Stimulus mixes directed cases with
//   randomized configuration offers and lock drops.
module tb_pll_lock_phase_gen;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 3;
    localparam int LOCK_WAIT   = 16;

    logic                    clock_in = 1'b0;
    logic                    resetb   = 1'b1;
    logic                    pll_locked = 1'b0;
    logic                    cfg_valid  = 1'b0;
    logic                    cfg_ready;
    logic [DIV_W-1:0]        cfg_div    = '0;
    logic [NUM_CH*DIV_W-1:0] cfg_phase  = '0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic                    running;
    logic [7:0]              unlock_count;

    pll_lock_phase_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .LOCK_WAIT(LOCK_WAIT)
    ) dut (
        .clock_in(clock_in), .resetb(resetb), .pll_locked(pll_locked),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
        .cfg_phase(cfg_phase), .clk_out(clk_out), .tick(tick),
        .running(running), .unlock_count(unlock_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tck;
        logic              run;
        logic              rdy;
        logic [7:0]        unl;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    int m_hist0, m_hist1;   // lock_s is pll_locked delayed by two edges
    int m_consec;           // consecutive cycles with lock_s high
    int m_run;
    int m_pos;              // position within the current period
    int m_div;
    int m_ph[NUM_CH];
    int m_pend;
    int m_sdiv;
    int m_sph[NUM_CH];
    int m_unl;

    task automatic model_reset();
        m_hist0 = 0; m_hist1 = 0; m_consec = 0; m_run = 0; m_pos = 0;
        m_div = DEFAULT_DIV; m_pend = 0; m_sdiv = 0; m_unl = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_ph[i] = 0; m_sph[i] = 0;
        end
    endtask

    task automatic model_step();
        obs_t e;
        int   div_e, per, hi, ph, p, old_run, active, do_apply;
        old_run = m_run;
        div_e   = (m_div == 0) ? 1 : m_div;
        per     = div_e + 1;
        hi      = per / 2;
        // RUN holds once lock_s has been high for more than LOCK_WAIT cycles
        // (one cycle in IDLE noticing it, then LOCK_WAIT cycles of hold-off).
        if (m_hist1 != 0) m_consec = (m_consec < LOCK_WAIT + 2) ? m_consec + 1 : m_consec;
        else              m_consec = 0;
        m_run  = (m_consec >= LOCK_WAIT + 1) ? 1 : 0;
        active = old_run && m_run;
        e = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ph = (m_ph[i] > m_div) ? m_div : m_ph[i];
            p  = (m_pos - ph + per) % per;
            e.clk[i] = active && (p < hi);
            e.tck[i] = active && (p == 0);
        end
        do_apply = m_pend && (!old_run || m_pos == div_e);
        m_pos = active ? ((m_pos == div_e) ? 0 : m_pos + 1) : 0;
        if (old_run && !m_run && m_unl < 255) m_unl++;
        if (do_apply) begin
            m_div = m_sdiv;
            for (int i = 0; i < NUM_CH; i++) m_ph[i] = m_sph[i];
            m_pend = 0;
        end else if (cfg_valid && !m_pend) begin
            m_sdiv = int'(cfg_div);
            for (int i = 0; i < NUM_CH; i++) m_sph[i] = int'(cfg_phase[i*DIV_W +: DIV_W]);
            m_pend = 1;
        end
        m_hist1 = m_hist0;
        m_hist0 = pll_locked ? 1 : 0;
        e.run = m_run[0];
        e.rdy = !m_pend;
        e.unl = 8'(m_unl);
        exp_q.push_back(e);
    endtask

    initial begin
        obs_t r;
        model_reset();
        forever begin
            @(posedge clock_in);
            if (!resetb) begin
                model_reset();
                r = '0;
                r.rdy = 1'b1;
                exp_q.push_back(r);
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clock_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {clk_out, tick, running, cfg_ready, unlock_count};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t got clk=%b tick=%b run=%b rdy=%b unl=%0d, expected clk=%b tick=%b run=%b rdy=%b unl=%0d",
                             $time, a.clk, a.tck, a.run, a.rdy, a.unl, e.clk, e.tck, e.run, e.rdy, e.unl);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic offer(input int div, input logic [NUM_CH*DIV_W-1:0] ph, input int hold);
        $display("cfg offer div=%0d phase=%h hold=%0d", div, ph, hold);
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(div);
        cfg_phase = ph;
        cycles(hold);
        cfg_valid = 1'b0;
    endtask

    // Wait (bounded) for running to reach a level; returns the cycles taken.
    task automatic wait_running(input logic level, input int budget, output int taken);
        taken = 0;
        while (running !== level && taken < budget) begin
            @(negedge clock_in);
            taken++;
        end
        if (running !== level) begin
            miscompares++;
            $display("FAIL wait_running level=%b not reached in %0d cycles", level, budget);
        end
    endtask

    task automatic lose_lock(input int n);
        int t;
        pll_locked = 1'b0;
        cycles(n);
        pll_locked = 1'b1;
        wait_running(1'b0, 10, t);
        wait_running(1'b1, LOCK_WAIT + 20, t);
    endtask

    function automatic logic [NUM_CH*DIV_W-1:0] rand_phase();
        logic [NUM_CH*DIV_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 11));
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int t;
        #1 resetb = 1'b0;
        #1;
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_unlock", 32'(unlock_count), 32'd0);
        cycles(3);
        resetb = 1'b1;

        // Phases 0,1,2,3 applied in IDLE, then lock at cycle ~10.
        offer(3, {8'd3, 8'd2, 8'd1, 8'd0}, 1);
        cycles(4);
        pll_locked = 1'b1;
        wait_running(1'b1, 60, t);
        $display("lock start: running after %0d cycles", t);
        check("lock_holdoff_min", 32'(t >= LOCK_WAIT + 1), 32'd1);
        check("lock_holdoff_max", 32'(t <= LOCK_WAIT + 3), 32'd1);
        cycles(30);

        // Mid-period reconfig to period 6, ch1 offset 3.
        cycles(1);
        offer(5, {8'd0, 8'd0, 8'd3, 8'd0}, 1);
        cycles(30);
        offer(0, {8'd1, 8'd0, 8'd1, 8'd0}, 1);
        cycles(12);
        offer(4, {8'd2, 8'd9, 8'd0, 8'd9}, 1);
        cycles(20);

        // Back-to-back offers: the second is ignored while the slot is full.
        $display("cfg back-to-back div=2 then div=7");
        cfg_valid = 1'b1; cfg_div = 8'd2; cfg_phase = {8'd1, 8'd1, 8'd0, 8'd0};
        cycles(1);
        cfg_div = 8'd7; cfg_phase = {8'd5, 8'd5, 8'd5, 8'd5};
        cycles(3);
        cfg_valid = 1'b0;
        cycles(20);

        $display("lock loss 1 cycle");
        lose_lock(1);
        cycles(10);

        for (int s = 0; s < 40; s++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act <= 5) begin
                offer($urandom_range(0, 9), rand_phase(), $urandom_range(1, 3));
                cycles($urandom_range(2, 15));
            end else if (act <= 7) begin
                $display("lock loss random");
                lose_lock($urandom_range(1, 3));
            end else begin
                cycles($urandom_range(5, 20));
            end
        end

        $display("lock loss x300");
        for (int k = 0; k < 300; k++) lose_lock(1);
        cycles(2);
        check("unlock_saturate", 32'(unlock_count), 32'd255);

        // Async reset with a pending config.
        cycles(3);
        offer(7, {8'd1, 8'd2, 8'd3, 8'd4}, 1);
        #2 resetb = 1'b0;
        #1;
        check("areset_clk_out", 32'(clk_out), 32'd0);
        check("areset_tick", 32'(tick), 32'd0);
        check("areset_running", 32'(running), 32'd0);
        check("areset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("areset_unlock", 32'(unlock_count), 32'd0);
        cycles(3);
        resetb = 1'b1;
        wait_running(1'b1, 60, t);
        cycles(24);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_phase_gen.md
Name: pll_lock_phase_gen

Overview:
- Fabric clock/strobe generator that sits downstream of an SB_PLL40 wrapper in the breakout gateware.
- Qualifies the PLL lock signal with a synchroniser and a hold-off counter.
- Then produces NUM_CH divided clock outputs from clock_in, each with its own programmable phase offset in whole clock_in cycles.
- Generalises the fixed single 90° output to N channels, runtime divide and phase, glitch-free reconfiguration, and lock-loss recovery.

Parameters:
- NUM_CH, 4, number of output channels.
- DIV_W, 8, width of the divide and phase fields.
- DEFAULT_DIV, 3, divide value after reset (period = DEFAULT_DIV+1 cycles).
- LOCK_WAIT, 1024, consecutive synchronised-lock cycles required before output starts (>=1).

Ports:
- clock_in  in  1  PLL output clock; the only clock.
- resetb  in  1  asynchronous, active-low reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous to clock_in.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  configuration slot free.
- cfg_div  in  DIV_W  divide value; period = cfg_div+1 cycles.
- cfg_phase  in  NUM_CH*DIV_W  per-channel phase; channel i at bits [i*DIV_W +: DIV_W].
- clk_out  out  NUM_CH  divided, phase-shifted outputs (registered).
- tick  out  NUM_CH  one-cycle strobe on each channel's rising edge.
- running  out  1  high in RUN state.
- unlock_count  out  8  saturating count of RUN->IDLE lock losses.

Behaviour:
- Reset values: clk_out=0, tick=0, running=0, cfg_ready=1, unlock_count=0, sync flops=0, cnt=0, div_act=DEFAULT_DIV, all phase_act=0, no pending config.
- Lock sync: pll_locked passes through two flops to give lock_s (2-cycle latency).
- FSM IDLE:
  - On lock_s=1, load wait counter and go to WAIT.
  - Outputs forced 0 and cnt held at 0.
- FSM WAIT:
  - Count consecutive lock_s=1 cycles; after LOCK_WAIT of them, go to RUN with cnt=0.
  - lock_s=0 returns to IDLE and clears the counter.
- FSM RUN:
  - running=1; cnt counts 0..div_act, then wraps to 0.
  - lock_s=0 returns to IDLE the next cycle: clk_out and tick go 0, cnt=0, unlock_count increments and saturates at 255.
- Effective divide: a div_act of 0 is treated as 1 (minimum period 2).
- Effective phase: any phase_i > div_act is clamped to div_act.
- Per-channel position:
  - p_i = cnt - ph_i when cnt >= ph_i, else cnt + div_act + 1 - ph_i.
  - hi = (div_act+1) >> 1.
- Registered outputs, one cycle latency from cnt:
  - clk_out_i(t+1) = running(t) & (p_i(t) < hi).
  - tick_i(t+1) = running(t) & (p_i(t) == 0).
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready on a rising edge; cfg_div and cfg_phase are captured into a shadow register and cfg_ready drops to 0.
  - cfg_valid held while cfg_ready=0 has no effect.
- Config apply:
  - In RUN, the shadow is copied to div_act/phase_act on the cycle cnt == div_act, so the new values take effect from cnt=0. The old period always completes, with no runt pulses.
  - In IDLE/WAIT, the shadow is applied on the next cycle.
  - cfg_ready returns to 1 on the cycle after the apply.
- Simultaneous lock loss and apply: the apply still occurs and unlock handling also occurs.
- Reset mid-operation: all state returns to its reset values immediately (asynchronous); the pending config is discarded.
- Odd periods: the high time is floor((div+1)/2) cycles.

Test Plan:
- Lock start: reset, pll_locked=1 at cycle 10, LOCK_WAIT=16 -> running rises at cycle 10+2+16 (±1); first clk_out rise one cycle later on ch0 (phase 0); tick aligned with it.
- Default waveform: DEFAULT_DIV=3, phases {0,1,2,3} -> each channel has period 4 and 2 high cycles; ch k rises k cycles after ch0; tick pulses every 4 cycles.
- Reconfig: in RUN, send cfg_div=5 and phases {0,3,0,0} mid-period -> cfg_ready=0 until the period boundary; the current 4-cycle period completes; then period 6, 3 high cycles, ch1 offset 3; cfg_ready=1 one cycle after apply.
- Edge values: cfg_div=0 -> period 2. cfg_div=4 with phase 9 -> phase clamped to 4, high time 2 of 5. Back-to-back cfg_valid -> second offer ignored until cfg_ready=1.
- Lock loss: drop pll_locked for 1 cycle in RUN -> clk_out=0 within 3 cycles; unlock_count=1; full LOCK_WAIT hold-off is repeated. After 300 losses unlock_count=255.
- Async reset: assert resetb=0 mid-period with a pending config -> all outputs 0 without a clock edge; after release, div_act=DEFAULT_DIV and the pending config is discarded.
